load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/load_align.sv | 18 +
 rtl/load_store_unit.sv | 114 +++++++++++
 tb/tb_load_store_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 size codes, FSM states and byte-enable constants for the load/store unit.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;
  // Reserved codes (011, 110, 111) fall through to word access.
  function automatic logic is_byte(input logic [2:0] f3);
    return f3[1:0] == F3_B[1:0];
  endfunction
  function automatic logic is_half(input logic [2:0] f3);
    return f3[1:0] == F3_H[1:0];
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: lane select and sign/zero extension of a 32-bit memory word for RV32 loads.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    result = is_byte(funct3) ? {{24{b[7] & ~funct3[2]}}, b} :
             is_half(funct3) ? {{16{h[15] & ~funct3[2]}}, h} : rdata;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32 load/store unit with pipeline stall; LSU_MISALIGN_TRAP_EN enables misalignment trapping.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_memr,
  input  logic              ex_memw,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  input  logic              ex_float,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_be,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_float,
  output logic [31:0]       wb_data,
  output logic              misalign
);
  state_e            state_q, state_d;
  logic              we_q, we_d, float_q, float_d, wb_valid_q, wb_valid_d, wb_float_q, wb_float_d, mis_q, mis_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, wb_data_q, wb_data_d, ld_data, st_data;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic [3:0]        st_be;
  logic              req, mis, accept, ack;
  load_align u_align (.rdata(dm_rdata), .off(off_q), .funct3(f3_q), .result(ld_data));
  always_comb begin
    req = (state_q == IDLE) & ex_valid & (ex_memr | ex_memw);
`ifdef LSU_MISALIGN_TRAP_EN
    mis = req & (is_byte(ex_funct3) ? 1'b0 : is_half(ex_funct3) ? ex_addr[0] : ex_addr[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    accept = req & ~mis;
    ack = (state_q == REQ) & dm_ack;
    st_be = is_byte(ex_funct3) ? BE_B << ex_addr[1:0] :
            is_half(ex_funct3) ? (ex_addr[1] ? BE_HI : BE_LO) : BE_ALL;
    st_data = is_byte(ex_funct3) ? {4{ex_wdata[7:0]}} :
              is_half(ex_funct3) ? {2{ex_wdata[15:0]}} : ex_wdata;
    state_d = accept ? REQ : ack ? IDLE : state_q;
    we_d = accept ? ex_memw : we_q;
    be_d = accept ? (ex_memw ? st_be : BE_ALL) : be_q;
    addr_d = accept ? {ex_addr[ADDR_W-1:2], 2'b00} : addr_q;
    wdata_d = accept ? (ex_memw ? st_data : 32'd0) : wdata_q;
    f3_d = accept ? ex_funct3 : f3_q;
    off_d = accept ? ex_addr[1:0] : off_q;
    rd_d = accept ? ex_rd : rd_q;
    float_d = accept ? ex_float : float_q;
    wb_valid_d = ack & ~we_q;
    wb_data_d = wb_valid_d ? ld_data : wb_data_q;
    wb_rd_d = wb_valid_d ? rd_q : wb_rd_q;
    wb_float_d = wb_valid_d ? float_q : wb_float_q;
    mis_d = mis;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      be_q <= BE_NONE;
      addr_q <= '0;
      wdata_q <= '0;
      f3_q <= F3_W;
      off_q <= '0;
      rd_q <= '0;
      float_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q <= '0;
      wb_float_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      be_q <= be_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      f3_q <= f3_d;
      off_q <= off_d;
      rd_q <= rd_d;
      float_q <= float_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q <= wb_data_d;
      wb_rd_q <= wb_rd_d;
      wb_float_q <= wb_float_d;
      mis_q <= mis_d;
    end
  end
  assign stall = accept | ((state_q == REQ) & ~dm_ack);
  assign dm_req = state_q == REQ;
  assign dm_we = we_q;
  assign dm_addr = addr_q;
  assign dm_be = be_q;
  assign dm_wdata = wdata_q;
  assign wb_valid = wb_valid_q;
  assign wb_data = wb_data_q;
  assign wb_rd = wb_rd_q;
  assign wb_float = wb_float_q;
  assign misalign = mis_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit (default and LSU_MISALIGN_TRAP_EN builds).
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ex_valid, ex_memr, ex_memw, ex_float;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata, dm_addr, dm_wdata, dm_rdata, wb_data;
  logic [4:0]  ex_rd, wb_rd;
  logic        stall, dm_req, dm_we, dm_ack, wb_valid, wb_float, misalign;
  logic [3:0]  dm_be;
  int passed = 0, total = 0;
  load_store_unit dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_memr(ex_memr), .ex_memw(ex_memw),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .ex_float(ex_float), .stall(stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_float(wb_float), .wb_data(wb_data), .misalign(misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic issue(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input logic fl);
    ex_valid = 1'b1; ex_memr = r; ex_memw = w; ex_funct3 = f3;
    ex_addr = a; ex_wdata = wd; ex_rd = rd; ex_float = fl;
  endtask
  initial begin
    ex_valid = 0; ex_memr = 0; ex_memw = 0; ex_funct3 = 0; ex_addr = 0; ex_wdata = 0;
    ex_rd = 0; ex_float = 0; dm_ack = 0; dm_rdata = 0;
    repeat (2) @(negedge clk);
    #1 chk("rst_dm_req", dm_req, 0); chk("rst_dm_be", dm_be, 0); chk("rst_dm_we", dm_we, 0);
    chk("rst_wb_valid", wb_valid, 0); chk("rst_wb_data", wb_data, 0); chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_float", wb_float, 0); chk("rst_misalign", misalign, 0);
    rst = 0;
    @(negedge clk);
    issue(1, 0, 3'b000, 32'h103, 0, 5'd5, 0);
    #1 chk("lb_stall_c0", stall, 1);
    @(negedge clk); ex_valid = 0;
    #1 chk("lb_dm_req", dm_req, 1); chk("lb_dm_addr", dm_addr, 32'h100); chk("lb_dm_we", dm_we, 0);
    chk("lb_dm_be", dm_be, 4'hF); chk("lb_stall_c1", stall, 1);
    @(negedge clk);
    #1 chk("lb_stall_c2", stall, 1); chk("lb_dm_req_c2", dm_req, 1);
    @(negedge clk); dm_ack = 1; dm_rdata = 32'h80FF_1234;
    #1 chk("lb_stall_ack", stall, 0);
    @(negedge clk); dm_ack = 0;
    #1 chk("lb_wb_valid", wb_valid, 1); chk("lb_wb_data", wb_data, 32'hFFFF_FF80);
    chk("lb_wb_rd", wb_rd, 5); chk("lb_dm_req_done", dm_req, 0);
    @(negedge clk);
    #1 chk("lb_wb_pulse", wb_valid, 0);
    issue(1, 1, 3'b001, 32'h22, 32'h0000_BEEF, 5'd7, 0);
    #1 chk("sh_stall", stall, 1);
    @(negedge clk); ex_valid = 0;
    #1 chk("sh_dm_we", dm_we, 1); chk("sh_dm_be", dm_be, 4'b1100);
    chk("sh_dm_wdata", dm_wdata, 32'hBEEF_BEEF); chk("sh_dm_addr", dm_addr, 32'h20);
    dm_ack = 1;
    #1 chk("sh_stall_ack", stall, 0);
    @(negedge clk); dm_ack = 0;
    #1 chk("sh_no_wb", wb_valid, 0); chk("sh_wb_data_kept", wb_data, 32'hFFFF_FF80);
    issue(1, 0, 3'b101, 32'h2, 0, 5'd9, 1);
    @(negedge clk); ex_valid = 0; dm_ack = 1; dm_rdata = 32'h8001_0000;
    #1 chk("lhu_dm_req", dm_req, 1); chk("lhu_stall_ack", stall, 0);
    @(negedge clk); dm_ack = 0;
    issue(0, 1, 3'b010, 32'h40, 32'h1234_5678, 5'd3, 0);
    #1 chk("lhu_wb_valid", wb_valid, 1); chk("lhu_wb_data", wb_data, 32'h0000_8001);
    chk("lhu_wb_rd", wb_rd, 9); chk("lhu_wb_float", wb_float, 1); chk("sw_b2b_stall", stall, 1);
    @(negedge clk); ex_valid = 0;
    #1 chk("sw_dm_req", dm_req, 1); chk("sw_dm_we", dm_we, 1); chk("sw_dm_be", dm_be, 4'hF);
    chk("sw_dm_addr", dm_addr, 32'h40); chk("sw_dm_wdata", dm_wdata, 32'h1234_5678);
    chk("sw_wb_clear", wb_valid, 0);
    dm_ack = 1;
    @(negedge clk); dm_ack = 0;
    issue(0, 1, 3'b000, 32'h41, 32'h0000_00A5, 5'd1, 0);
    @(negedge clk); ex_valid = 0;
    #1 chk("sb_dm_be", dm_be, 4'b0010); chk("sb_dm_wdata", dm_wdata, 32'hA5A5_A5A5);
    dm_ack = 1;
    @(negedge clk); dm_ack = 0;
    issue(1, 0, 3'b001, 32'h2, 0, 5'd4, 0);
    @(negedge clk); ex_valid = 0; dm_ack = 1; dm_rdata = 32'h8001_0000;
    @(negedge clk); dm_ack = 0;
    #1 chk("lh_wb_data", wb_data, 32'hFFFF_8001);
    issue(1, 0, 3'b011, 32'h8, 0, 5'd8, 0);
    @(negedge clk); ex_valid = 0;
    #1 chk("rsv_dm_be", dm_be, 4'hF);
    dm_ack = 1; dm_rdata = 32'hDEAD_BEEF;
    @(negedge clk); dm_ack = 0;
    #1 chk("rsv_wb_data", wb_data, 32'hDEAD_BEEF);
    issue(1, 0, 3'b010, 32'h80, 0, 5'd6, 0);
    @(negedge clk); ex_valid = 0;
    #1 chk("rstreq_dm_req_c1", dm_req, 1);
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0; dm_ack = 1; dm_rdata = 32'hFFFF_FFFF;
    #1 chk("rstreq_dm_req", dm_req, 0); chk("rstreq_dm_be", dm_be, 0); chk("idle_ack_stall", stall, 0);
    @(negedge clk); dm_ack = 0;
    #1 chk("rstreq_no_wb", wb_valid, 0); chk("rstreq_wb_data", wb_data, 0); chk("idle_ack_dm_req", dm_req, 0);
    issue(1, 0, 3'b010, 32'h6, 0, 5'd2, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    #1 chk("mis_stall", stall, 0);
    @(negedge clk); ex_valid = 0;
    #1 chk("mis_pulse", misalign, 1); chk("mis_dm_req", dm_req, 0);
    @(negedge clk);
    #1 chk("mis_pulse_end", misalign, 0); chk("mis_no_wb", wb_valid, 0); chk("mis_dm_req_after", dm_req, 0);
`else
    #1 chk("lw6_stall", stall, 1);
    @(negedge clk); ex_valid = 0;
    #1 chk("lw6_dm_addr", dm_addr, 32'h4); chk("lw6_misalign", misalign, 0);
    dm_ack = 1; dm_rdata = 32'h1122_3344;
    @(negedge clk); dm_ack = 0;
    #1 chk("lw6_wb_data", wb_data, 32'h1122_3344); chk("lw6_wb_valid", wb_valid, 1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
